// File: rtl/axi_rd_slave.sv
// rtl/axi_rd_slave.sv - AXI-style read responder splitting bursts into controller chunk reads
//
// Accepts one read burst at a time on the AR channel, issues RBURST_LEN-beat
// chunk requests to the DDR2 controller read port, buffers returned beats in a
// FIFO and replays them on the R channel with rready backpressure and rlast.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   init_end              DDR2 initialisation complete (gates arready)
//   axi_ar*               read address channel (valid/ready/addr/len)
//   axi_r*                read data channel (valid/ready/data/last)
//   ctrl_rd_req/ack/addr  chunk request handshake to the controller
//   ctrl_rd_data/_vld     returned beats, no backpressure

module axi_rd_slave #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 16,
  parameter int DATA_LEVEL = 2,
  parameter int RBURST_LEN = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [7:0]            axi_arlen,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic                  axi_rlast,
  output logic                  ctrl_rd_req,
  input  logic                  ctrl_rd_ack,
  output logic [ADDR_WIDTH-1:0] ctrl_rd_addr,
  input  logic [DATA_WIDTH-1:0] ctrl_rd_data,
  input  logic                  ctrl_rd_data_vld
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (RBURST_LEN > 1) ? $clog2(RBURST_LEN) : 1;
  localparam logic [AW:0]           DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]           CHUNK_C    = (AW+1)'(RBURST_LEN);
  localparam logic [CW-1:0]         LAST_BEAT  = CW'(RBURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(RBURST_LEN * DATA_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t                  state_q;
  logic                    arready_q;
  logic [ADDR_WIDTH-1:0]   cur_addr_q;
  logic [8:0]              total_q;
  logic [8:0]              pushed_q;
  logic [CW-1:0]           chunk_cnt_q;
  logic                    last_out_q;

  logic [DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
  logic                    mem_last [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q;
  logic [AW-1:0]           rd_ptr_q;
  logic [AW:0]             count_q;

  logic       ar_fire;
  logic       space_ok;
  logic       fifo_empty;
  logic       pop;
  logic       last_pop;
  logic       beat;
  logic       push;
  logic [8:0] pushed_nx;
  logic       burst_done;

  assign ar_fire    = axi_arvalid & arready_q;
  assign axi_arready = arready_q;

  // Only one chunk is ever outstanding, so requiring a whole chunk of free
  // space before requesting guarantees the FIFO can never overflow.
  assign space_ok    = (DEPTH_C - count_q) >= CHUNK_C;
  assign ctrl_rd_req  = (state_q == S_REQ) & space_ok;
  assign ctrl_rd_addr = cur_addr_q;

  assign fifo_empty = (count_q == '0);
  assign axi_rvalid = ~fifo_empty;
  assign axi_rdata  = fifo_empty ? '0 : mem_data[rd_ptr_q];
  assign axi_rlast  = ~fifo_empty & mem_last[rd_ptr_q];
  assign pop        = axi_rvalid & axi_rready;
  assign last_pop   = pop & axi_rlast;

  // Beats beyond the burst length (tail of a partial final chunk) are dropped.
  assign beat       = (state_q == S_WAIT) & ctrl_rd_data_vld;
  assign push       = beat & (pushed_q < total_q);
  assign pushed_nx  = pushed_q + 9'(push);
  assign burst_done = (pushed_nx == total_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      arready_q   <= 1'b0;
      cur_addr_q  <= '0;
      total_q     <= '0;
      pushed_q    <= '0;
      chunk_cnt_q <= '0;
      last_out_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      if (last_pop) begin
        last_out_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          arready_q <= init_end & ~ar_fire;
          if (ar_fire) begin
            cur_addr_q <= axi_araddr;
            total_q    <= {1'b0, axi_arlen} + 9'd1;
            pushed_q   <= '0;
            last_out_q <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (ctrl_rd_req && ctrl_rd_ack) begin
            cur_addr_q  <= cur_addr_q + ADDR_STEP;
            chunk_cnt_q <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (beat) begin
            pushed_q    <= pushed_nx;
            chunk_cnt_q <= chunk_cnt_q + CW'(1);
            if (chunk_cnt_q == LAST_BEAT) begin
              if (!burst_done) begin
                state_q <= S_REQ;
              end else if (last_out_q || last_pop) begin
                // A short burst can be fully drained before the chunk ends.
                state_q   <= S_IDLE;
                arready_q <= init_end;
              end else begin
                state_q <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (last_pop) begin
            state_q   <= S_IDLE;
            arready_q <= init_end;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= ctrl_rd_data;
      mem_last[wr_ptr_q] <= (pushed_q == total_q - 9'd1);
    end
  end

endmodule

// File: doc/axi_rd_slave.md
# axi_rd_slave

AXI-style read responder for the DDR2 controller's host port: the target end of the `axi_ar*`/`axi_r*` channel driven by `axi_rd_master`. It accepts one read burst at a time and splits it into fixed-length `RBURST_LEN` chunk requests on the controller's internal read-command port. Returned beats are buffered in an internal FIFO and replayed on the R channel with `rready` backpressure and `rlast` marking.

## Interface
Parameters:
- `ADDR_WIDTH`, default 27: byte-lane word address width (ROW+COL+BA).
- `DATA_WIDTH`, default 16: beat width (DQ_BITS*DATA_LEVEL).
- `DATA_LEVEL`, default 2: address units per beat.
- `RBURST_LEN`, default 8: beats per controller chunk request.
- `FIFO_DEPTH`, default 32: read buffer depth in beats; power of 2, ≥ `RBURST_LEN`.

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `init_end`  in  1  DDR2 initialisation complete.
- `axi_arvalid`  in  1  read address valid.
- `axi_arready`  out  1  read address ready.
- `axi_araddr`  in  ADDR_WIDTH  burst start address.
- `axi_arlen`  in  8  beats minus 1.
- `axi_rvalid`  out  1  read data valid.
- `axi_rready`  in  1  read data ready.
- `axi_rdata`  out  DATA_WIDTH  read data.
- `axi_rlast`  out  1  final beat of burst.
- `ctrl_rd_req`  out  1  chunk request to controller.
- `ctrl_rd_ack`  in  1  controller accepted request.
- `ctrl_rd_addr`  out  ADDR_WIDTH  chunk start address.
- `ctrl_rd_data`  in  DATA_WIDTH  returned beat.
- `ctrl_rd_data_vld`  in  1  returned beat valid; no backpressure.

## Operation
- Registers: `cur_addr`, `total = arlen+1` (9 bits), `pushed` (9 bits), `chunk_cnt` (0..RBURST_LEN-1), FIFO of {last, data}.
- State IDLE: `axi_arready = init_end`. On `arvalid & arready`, latch address and `total`, clear `pushed`, go to REQ.
- State REQ: `ctrl_rd_req = 1` only while FIFO free space ≥ `RBURST_LEN`. `ctrl_rd_addr = cur_addr`. On `req & ack`, `cur_addr += RBURST_LEN*DATA_LEVEL` (mod 2^ADDR_WIDTH), clear `chunk_cnt`, go to WAIT.
- State WAIT: each `ctrl_rd_data_vld` increments `chunk_cnt`. The beat is pushed only if `pushed < total`, with `last = (pushed == total-1)`. Excess beats of a partial final chunk are dropped. After the `RBURST_LEN`-th beat: go to DRAIN if `pushed == total` (counting this beat), else go to REQ.
- State DRAIN: go to IDLE in the cycle the `last` entry is popped (`rvalid & rready & rlast`).
- Only one chunk is outstanding at a time, so the free-space gating makes FIFO overflow impossible.
- `ctrl_rd_data_vld` in any state other than WAIT is ignored.
- R channel: `axi_rvalid = !fifo_empty`; `axi_rdata`/`axi_rlast` come from the FIFO head. Pop on `rvalid & rready`. Data and last stay stable while `rvalid & !rready`.
- Simultaneous push and pop in the same cycle: both take effect and the count is unchanged. A full FIFO plus push cannot occur.

## Timing
- Reset values: `axi_arready=0`, `axi_rvalid=0`, `axi_rlast=0`, `axi_rdata=0`, `ctrl_rd_req=0`, `ctrl_rd_addr=0`. State returns to IDLE and the FIFO empties.
- `rst` asserted mid-burst aborts immediately. Beats pending in the controller after reset are ignored (state IDLE).
- AR handshake at cycle T: `ctrl_rd_req` high at T+1 if space is available.
- A registered FIFO write gives push→`rvalid` latency of 1 cycle.
- Back-to-back R beats at 1 per cycle when `rready` is held high.
- Next `arready` asserts the cycle after the final `rlast` handshake.
- `ctrl_rd_req` deasserts the cycle after `ack`. It is held while waiting for ack and does not drop before ack.
- `arready` stays 0 while `init_end=0`, even with `arvalid` held high.

## Test plan
- `init_end=0`, `arvalid=1`: `arready` stays 0 for 100 cycles. Raise `init_end`: handshake occurs within 1 cycle.
- `araddr=0x40`, `arlen=7`, `rready=1`, controller returns 8 beats 1..8: one request at addr 0x40, 8 R beats 1..8, `rlast` only on beat 8, then `arready=1`.
- `arlen=47` at addr 0: 6 requests at 0x00, 0x10, 0x20, 0x30, 0x40, 0x50. 48 beats in order, with `rlast` on beat 48.
- `arlen=9`: 2 chunk requests (16 beats returned). Only 10 R beats are produced, with `rlast` on the 10th, and 6 beats are dropped.
- `arlen=63`, `FIFO_DEPTH=32`, `rready=0`: requests stall after 4 chunks (FIFO full at 32). Releasing `rready` resumes requests. All 64 beats arrive in order with no loss.
- Random `rready` toggling, then `rst` pulsed mid-burst: all outputs go to reset values asynchronously. A new `arlen=7` burst afterwards completes correctly.
